// File: rtl/hart_issue_sched.sv
// Round-robin hart issue scheduler: rotating slot counter, active-hart mask, registered issue outputs.
// Optional stall input enabled by defining HART_SCHED_STALL_EN.
module hart_issue_sched #(
   parameter int NUM_HARTS = 16,
   parameter int HART_W    = $clog2(NUM_HARTS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_start,
   input  logic                 i_halt_valid,
   input  logic [HART_W-1:0]    i_halt_hart,
   input  logic                 i_wake_valid,
   input  logic [HART_W-1:0]    i_wake_hart,
`ifdef HART_SCHED_STALL_EN
   input  logic                 i_stall,
`endif
   output logic [HART_W-1:0]    o_hart_id,
   output logic                 o_issue_valid,
   output logic [NUM_HARTS-1:0] o_active_mask,
   output logic                 o_all_halted
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                state;
   logic                  stall;
   logic [NUM_HARTS-1:0]  mask_next;
   logic [HART_W-1:0]     hart_next;

`ifdef HART_SCHED_STALL_EN
   assign stall = i_stall;
`else
   assign stall = 1'b0;
`endif

   // Per-bit decode: out-of-range hart indices match no bit and are dropped; wake is OR'd last so it wins.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_HARTS; gi++) begin : g_mask
         logic halt_hit;
         logic wake_hit;
         assign halt_hit = i_halt_valid && (i_halt_hart == HART_W'(gi));
         assign wake_hit = i_wake_valid && (i_wake_hart == HART_W'(gi));
         assign mask_next[gi] = (state == RUN)
                              ? ((o_active_mask[gi] & ~halt_hit) | wake_hit)
                              : o_active_mask[gi];
      end
   endgenerate

   assign hart_next = stall ? o_hart_id
                    : (o_hart_id == HART_W'(NUM_HARTS - 1)) ? '0
                    : o_hart_id + HART_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         o_hart_id     <= '0;
         o_issue_valid <= 1'b0;
         o_active_mask <= '0;
         o_all_halted  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_start) begin
                  state         <= RUN;
                  o_hart_id     <= '0;
                  o_issue_valid <= 1'b1;
                  o_active_mask <= '1;
                  o_all_halted  <= 1'b0;
               end
            end
            RUN: begin
               // Issue decision uses this edge's mask updates, so a halt lands on the slot it selects.
               o_active_mask <= mask_next;
               o_hart_id     <= hart_next;
               o_issue_valid <= !stall && mask_next[hart_next];
               o_all_halted  <= (mask_next == '0);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hart_issue_sched.sv
// Scoreboard bench: two schedulers (4 and 3 harts) share random/directed stimulus and are
// compared every cycle against a slot/array reference model.
module tb_hart_issue_sched;

   typedef struct packed {
      logic [1:0] id;
      logic       v;
      logic [3:0] mask;
      logic       ah;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       hv = 1'b0;
   logic [1:0] hh = '0;
   logic       wv = 1'b0;
   logic [1:0] wh = '0;
   logic       stall = 1'b0;

   logic [1:0] id4, id3;
   logic       v4, v3, ah4, ah3;
   logic [3:0] mask4;
   logic [2:0] mask3;

   int checks = 0;
   int errors = 0;

   exp_t q4[$];
   exp_t q3[$];

   // Reference model state: one entry per DUT (0 = 4 harts, 1 = 3 harts)
   bit         m_run[2];
   int         m_id[2];
   bit         m_v[2];
   logic [3:0] m_act[2];

   always #5 clk = ~clk;

   hart_issue_sched #(.NUM_HARTS(4)) dut4 (
      .clk(clk), .reset(reset), .i_start(start),
      .i_halt_valid(hv), .i_halt_hart(hh), .i_wake_valid(wv), .i_wake_hart(wh),
`ifdef HART_SCHED_STALL_EN
      .i_stall(stall),
`endif
      .o_hart_id(id4), .o_issue_valid(v4), .o_active_mask(mask4), .o_all_halted(ah4)
   );

   hart_issue_sched #(.NUM_HARTS(3)) dut3 (
      .clk(clk), .reset(reset), .i_start(start),
      .i_halt_valid(hv), .i_halt_hart(hh), .i_wake_valid(wv), .i_wake_hart(wh),
`ifdef HART_SCHED_STALL_EN
      .i_stall(stall),
`endif
      .o_hart_id(id3), .o_issue_valid(v3), .o_active_mask(mask3), .o_all_halted(ah3)
   );

   // Predict the outputs visible after the coming rising edge from the current inputs.
   task automatic model_step(input int d, input int n);
      exp_t e;
      if (reset) begin
         m_run[d] = 0; m_id[d] = 0; m_v[d] = 0; m_act[d] = '0;
      end else if (!m_run[d]) begin
         if (start) begin
            m_run[d] = 1; m_id[d] = 0; m_v[d] = 1;
            m_act[d] = 4'((1 << n) - 1);
         end
      end else begin
         if (hv && int'(hh) < n) m_act[d][hh] = 1'b0;
         if (wv && int'(wh) < n) m_act[d][wh] = 1'b1;
         if (!stall) m_id[d] = (m_id[d] + 1) % n;
         m_v[d] = !stall && m_act[d][m_id[d]];
      end
      e.id   = 2'(m_id[d]);
      e.v    = m_v[d];
      e.mask = m_act[d];
      e.ah   = m_run[d] && (m_act[d] == 4'b0);
      if (d == 0) q4.push_back(e);
      else        q3.push_back(e);
   endtask

   task automatic step(input logic r, input logic s, input logic h_v, input logic [1:0] h_h,
                       input logic w_v, input logic [1:0] w_h, input logic st);
      logic was_reset;
      @(negedge clk);
      was_reset = reset;
      reset = r; start = s; hv = h_v; hh = h_h; wv = w_v; wh = w_h;
`ifdef HART_SCHED_STALL_EN
      stall = st;
`else
      stall = 1'b0 & st;
`endif
      model_step(0, 4);
      model_step(1, 3);
      if (r && !was_reset) begin
         #1;
         checks++;
         if ({id4, v4, mask4, ah4, id3, v3, mask3, ah3} != '0) begin
            errors++;
            $display("FAIL async_reset: dut4 id=%0d v=%0b mask=%b ah=%0b dut3 id=%0d v=%0b mask=%b ah=%0b, required all zero",
                     id4, v4, mask4, ah4, id3, v3, mask3, ah3);
         end
      end
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(0, 0, 0, 2'd0, 0, 2'd0, 0);
   endtask

   // Monitors: pop one expectation per rising edge and compare.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (q4.size() > 0) begin
            exp_t e, a;
            e = q4.pop_front();
            a = {id4, v4, mask4, ah4};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL dut4_slot @%0t: got id=%0d v=%0b mask=%b ah=%0b, required id=%0d v=%0b mask=%b ah=%0b",
                        $time, a.id, a.v, a.mask, a.ah, e.id, e.v, e.mask, e.ah);
            end else
               $display("txn dut4 @%0t id=%0d v=%0b mask=%b ah=%0b ok", $time, a.id, a.v, a.mask, a.ah);
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         if (q3.size() > 0) begin
            exp_t e, a;
            e = q3.pop_front();
            a = {id3, v3, 1'b0, mask3, ah3};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL dut3_slot @%0t: got id=%0d v=%0b mask=%b ah=%0b, required id=%0d v=%0b mask=%b ah=%0b",
                        $time, a.id, a.v, a.mask, a.ah, e.id, e.v, e.mask, e.ah);
            end else
               $display("txn dut3 @%0t id=%0d v=%0b mask=%b ah=%0b ok", $time, a.id, a.v, a.mask, a.ah);
         end
      end
   end

   initial begin
      // Reset held, then idle with start low
      step(1, 0, 0, 2'd0, 0, 2'd0, 0);
      step(1, 0, 0, 2'd0, 0, 2'd0, 0);
      idle(10);
      // Halt/wake in IDLE must be ignored
      step(0, 0, 1, 2'd1, 1, 2'd2, 0);
      // Start and rotation
      step(0, 1, 0, 2'd0, 0, 2'd0, 0);
      idle(6);
      // Mid-cycle reset, then restart and halt hart 2 on the edge selecting hart 1
      step(1, 0, 0, 2'd0, 0, 2'd0, 0);
      step(0, 1, 0, 2'd0, 0, 2'd0, 0);
      step(0, 0, 1, 2'd2, 0, 2'd0, 0);
      idle(5);
      step(0, 0, 0, 2'd0, 1, 2'd2, 0);
      idle(4);
      // Collisions and out-of-range index (3 on the 3-hart instance)
      step(0, 0, 1, 2'd3, 1, 2'd3, 0);
      step(0, 0, 1, 2'd0, 1, 2'd1, 0);
      step(0, 0, 1, 2'd3, 0, 2'd0, 0);
      idle(3);
      // Everything halted, then wake hart 1
      for (int h = 0; h < 4; h++) step(0, 0, 1, 2'(h), 0, 2'd0, 0);
      idle(6);
      step(0, 0, 0, 2'd0, 1, 2'd1, 0);
      idle(6);
      // Stall hold for 3 cycles (no effect without the stall build)
      for (int i = 0; i < 3; i++) step(0, 0, 0, 2'd0, 0, 2'd0, 1);
      step(0, 0, 1, 2'd1, 0, 2'd0, 1);
      idle(4);
      // Randomized traffic with occasional reset and restart
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
              $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
              $urandom_range(0, 3) == 0);
      // Final mid-run reset
      step(0, 1, 0, 2'd0, 0, 2'd0, 0);
      idle(3);
      step(1, 0, 0, 2'd0, 0, 2'd0, 0);
      idle(2);
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (q4.size() != 0 || q3.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d/%0d entries left, required 0", q4.size(), q3.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hart_issue_sched.md
# hart_issue_sched

Round-robin hart issue scheduler for the barrel pipeline. Every cycle it selects the next hart slot, tracks which harts are active (halted/woken by downstream stages), and emits a registered hart ID plus a one-bit issue-valid flag. Its outputs feed the fetch stage directly. The single-bit pipeline delay stages carry `o_issue_valid` alongside the instruction through the pipe.

## Interface
- `NUM_HARTS`, default 16: number of hart slots. Any value ≥ 2; a power of two is not required.
- `HART_W`, default `$clog2(NUM_HARTS)`: width of hart-ID fields.

- `clk`, in, 1: clock; all state on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `i_start`, in, 1: in IDLE, a sampled-high pulse starts issuing.
- `i_halt_valid`, in, 1: halt request for `i_halt_hart`.
- `i_halt_hart`, in, `HART_W`: hart to halt.
- `i_wake_valid`, in, 1: wake request for `i_wake_hart`.
- `i_wake_hart`, in, `HART_W`: hart to wake.
- `i_stall`, in, 1: present only with `HART_SCHED_STALL_EN`.
- `o_hart_id`, out, `HART_W`: hart owning the current slot (registered).
- `o_issue_valid`, out, 1: current slot carries a valid issue (registered).
- `o_active_mask`, out, `NUM_HARTS`: bit h = 1 means hart h is active.
- `o_all_halted`, out, 1: RUN state and `o_active_mask == 0`.

## Operation
- **States:**
  - IDLE: reset state.
  - RUN: entered when `i_start` is sampled high in IDLE; there is no return to IDLE except through `reset`.
  - `i_start` is ignored in RUN.
- **Reset values (async, immediate):** state = IDLE; `o_hart_id` = 0; `o_issue_valid` = 0; `o_active_mask` = 0; `o_all_halted` = 0.
- **Start edge:**
  - Mask becomes all ones.
  - `o_hart_id` = 0.
  - `o_issue_valid` = 1.
- **Slot counter in RUN:**
  - `o_hart_id` increments by 1 every edge.
  - It wraps from `NUM_HARTS-1` to 0.
  - Values ≥ `NUM_HARTS` never appear.
- **Issue valid per edge:** `o_issue_valid` <= `mask_next[hart_next]`, where `mask_next` already includes this edge's halt/wake updates.
- **Mask update in RUN, per edge:**
  - Halt clears bit `i_halt_hart`.
  - Wake sets bit `i_wake_hart`.
  - Halt and wake for different harts are both applied.
  - Halt and wake for the same hart in the same cycle: wake wins, and the bit ends at 1.
  - Halt/wake with hart index ≥ `NUM_HARTS` is ignored.
  - Halt/wake in IDLE is ignored.
- **All harts halted:**
  - The counter keeps rotating, so slot timing is fixed.
  - `o_issue_valid` stays 0.
  - `o_all_halted` = 1.
  - A wake restores issue on that hart's next slot.
- **Reset mid-operation:** everything returns to reset values; pending requests are discarded.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Halt/wake sampled at edge E takes effect in `o_active_mask` after E.
- That same edge E also decides the slot issued after E. A halt for hart h at the edge that selects h therefore suppresses that slot.
- `o_all_halted` is registered and tracks `o_active_mask` in the same cycle.
- Start latency: `i_start` high at edge E0 gives the first valid slot (hart 0) visible right after E0.
- Each hart gets exactly one slot every `NUM_HARTS` cycles (no stall configured).

## Configuration
- Macro: `HART_SCHED_STALL_EN`.
- **Defined:**
  - Port `i_stall` exists.
  - While `i_stall` is sampled high in RUN, `o_hart_id` holds its value and `o_issue_valid` <= 0.
  - Halt/wake updates continue to apply during stall.
  - On the first edge with `i_stall` low, the counter advances from the held value. Issue-valid then follows the normal rule.
- **Undefined:**
  - Port `i_stall` is absent.
  - Behaviour is identical to `i_stall` tied low.

## Test plan
All scenarios use `NUM_HARTS=4`.

1. **Reset/idle.** Assert `reset` mid-cycle, release, and hold `i_start`=0 for 10 cycles.
   -> All outputs are 0 immediately on assertion and stay 0.
2. **Start/rotation.** Pulse `i_start` at E0.
   -> `o_hart_id` sequence 0,1,2,3,0,1 over E0..E5.
   -> `o_issue_valid`=1 throughout.
   -> `o_active_mask`=4'b1111.
3. **Halt/wake.** After start, halt hart 2 at the edge selecting hart 1.
   -> Mask 4'b1011.
   -> The hart-2 slot has `o_issue_valid`=0.
   -> Wake hart 2 later and its next slot shows `o_issue_valid`=1.
4. **Collisions.**
   - Halt and wake hart 3 in the same cycle -> bit 3 stays 1.
   - Halt hart 0 and wake hart 1 in the same cycle -> both applied.
   - Halt index 5 (`HART_W`=2 truncation excluded: use `NUM_HARTS`=3, index 3) -> ignored.
5. **All halted.** Halt harts 0–3 on successive cycles.
   -> `o_all_halted`=1 and `o_issue_valid`=0 while `o_hart_id` keeps wrapping.
   -> Waking hart 1 gives a valid slot exactly when `o_hart_id`=1.
6. **Stall (macro defined) and mid-run reset.**
   - Raise `i_stall` for 3 cycles at `o_hart_id`=2 -> ID holds at 2 with valid=0, then resumes 3,0.
   - Assert `reset` mid-run -> IDLE and zeros immediately.
